// File: rtl/response_sender_pkg.sv
// Shared types and constants for the response transmit path: frame FSM,
// per-byte bit FSM and UART framing constants.
package response_sender_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS       = 8;
  localparam int   FRAME_BYTES     = 2;

  typedef enum logic [1:0] {
    FRAME_IDLE      = 2'd0,
    FRAME_SEND_CODE = 2'd1,
    FRAME_SEND_DATA = 2'd2,
    FRAME_DONE      = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_START = 2'd1,
    BIT_DATA  = 2'd2,
    BIT_STOP  = 2'd3
  } bit_state_t;

  // Clock cycles one whole frame occupies on the line (start + data + stop per byte).
  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BYTES * (DATA_BITS + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/response_sender_if.sv
// Request/line bundle between the response logic (master) and response_sender (slave).
interface response_sender_if;
  logic       i_Send;
  logic [7:0] i_Code;
  logic [7:0] i_Data;
  logic       o_Busy;
  logic       o_Tx_Serial;
  logic       o_Done;

  modport master (
    output i_Send, i_Code, i_Data,
    input  o_Busy, o_Tx_Serial, o_Done
  );

  modport slave (
    input  i_Send, i_Code, i_Data,
    output o_Busy, o_Tx_Serial, o_Done
  );
endinterface

// File: rtl/response_sender_uart_tx.sv
// 8N1 LSB-first UART byte transmitter. o_Tx_Done is high during the last
// stop-bit cycle, and a new i_Tx_DV in that cycle chains the next byte gap-free.
module uart_tx
  import response_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       IDX_LAST     = 3'(DATA_BITS - 1);

  bit_state_t       state_r;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             serial_r;
  logic             active_r;
  logic             done_r;

  // Bit FSM: shift_r[0] always holds the data bit currently on the line.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_r   <= BIT_IDLE;
      clk_cnt_r <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      serial_r  <= UART_IDLE_LEVEL;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        BIT_IDLE: begin
          clk_cnt_r <= '0;
          bit_idx_r <= 3'd0;
          if (i_Tx_DV) begin
            shift_r  <= i_Tx_Byte;
            serial_r <= 1'b0;
            active_r <= 1'b1;
            state_r  <= BIT_START;
          end else begin
            serial_r <= UART_IDLE_LEVEL;
            active_r <= 1'b0;
          end
        end
        BIT_START: begin
          if (clk_cnt_r == CNT_LAST) begin
            clk_cnt_r <= '0;
            serial_r  <= shift_r[0];
            state_r   <= BIT_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end
        BIT_DATA: begin
          if (clk_cnt_r == CNT_LAST) begin
            clk_cnt_r <= '0;
            if (bit_idx_r == IDX_LAST) begin
              bit_idx_r <= 3'd0;
              serial_r  <= UART_IDLE_LEVEL;
              state_r   <= BIT_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              serial_r  <= shift_r[1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end
        BIT_STOP: begin
          // Registered done lands exactly on the final stop-bit cycle.
          if (clk_cnt_r == CNT_PRE_LAST) begin
            done_r <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
          if (clk_cnt_r == CNT_LAST) begin
            clk_cnt_r <= '0;
            if (i_Tx_DV) begin
              shift_r  <= i_Tx_Byte;
              serial_r <= 1'b0;
              state_r  <= BIT_START;
            end else begin
              serial_r <= UART_IDLE_LEVEL;
              active_r <= 1'b0;
              state_r  <= BIT_IDLE;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r  <= BIT_IDLE;
          serial_r <= UART_IDLE_LEVEL;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_Tx_Active = active_r;
  assign o_Tx_Serial = serial_r;
  assign o_Tx_Done   = done_r;

endmodule

// File: rtl/response_sender.sv
// Two-byte response frame sender: code byte then data byte, back to back on
// one UART line, with a one-cycle o_Done once the data stop bit has ended.
module response_sender
  import response_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               i_Clock,
  input  logic               i_Rst,
  response_sender_if.slave   bus
);

  frame_state_t frame_state_r;
  logic [7:0]   data_r;
  logic         busy_r;
  logic         done_r;

  logic         tx_dv_s;
  logic [7:0]   tx_byte_s;
  logic         tx_active_s;
  logic         tx_serial_s;
  logic         tx_done_s;

  // Byte hand-off: the code byte goes straight from the request, the data
  // byte is chained into the code byte's final stop-bit cycle.
  always_comb begin
    tx_dv_s   = 1'b0;
    tx_byte_s = bus.i_Code;
    case (frame_state_r)
      FRAME_IDLE, FRAME_DONE: tx_dv_s = bus.i_Send;
      FRAME_SEND_CODE: begin
        tx_dv_s   = tx_done_s & tx_active_s;
        tx_byte_s = data_r;
      end
      default: tx_dv_s = 1'b0;
    endcase
  end

  // Frame FSM; DONE accepts a new request just like IDLE.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      frame_state_r <= FRAME_IDLE;
      data_r        <= 8'h00;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (frame_state_r)
        FRAME_IDLE, FRAME_DONE: begin
          if (bus.i_Send) begin
            data_r        <= bus.i_Data;
            busy_r        <= 1'b1;
            frame_state_r <= FRAME_SEND_CODE;
          end else begin
            busy_r        <= 1'b0;
            frame_state_r <= FRAME_IDLE;
          end
        end
        FRAME_SEND_CODE: begin
          if (tx_done_s) begin
            frame_state_r <= FRAME_SEND_DATA;
          end else begin
            frame_state_r <= FRAME_SEND_CODE;
          end
        end
        FRAME_SEND_DATA: begin
          if (tx_done_s) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
            frame_state_r <= FRAME_DONE;
          end else begin
            frame_state_r <= FRAME_SEND_DATA;
          end
        end
        default: begin
          busy_r        <= 1'b0;
          frame_state_r <= FRAME_IDLE;
        end
      endcase
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .i_Clock     (i_Clock),
    .i_Rst       (i_Rst),
    .i_Tx_DV     (tx_dv_s),
    .i_Tx_Byte   (tx_byte_s),
    .o_Tx_Active (tx_active_s),
    .o_Tx_Serial (tx_serial_s),
    .o_Tx_Done   (tx_done_s)
  );

  assign bus.o_Busy      = busy_r;
  assign bus.o_Done      = done_r;
  assign bus.o_Tx_Serial = tx_serial_s;

endmodule

// File: tb/tb_response_sender.sv
// Bench for response_sender: two instances (4 and 2 clocks per bit), per-cycle
// line/busy/done checks plus a UART-rx monitor scoring bytes against a queue.
module tb_response_sender;

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] send_v;
  logic [7:0] code_v [2];
  logic [7:0] data_v [2];

  always #5 clk = ~clk;

  response_sender_if bus0 ();
  response_sender_if bus1 ();

  assign bus0.i_Send = send_v[0];
  assign bus0.i_Code = code_v[0];
  assign bus0.i_Data = data_v[0];
  assign bus1.i_Send = send_v[1];
  assign bus1.i_Code = code_v[1];
  assign bus1.i_Data = data_v[1];

  wire [1:0] line_w = {bus1.o_Tx_Serial, bus0.o_Tx_Serial};
  wire [1:0] busy_w = {bus1.o_Busy, bus0.o_Busy};
  wire [1:0] done_w = {bus1.o_Done, bus0.o_Done};

  response_sender #(.CLKS_PER_BIT(4)) dut0 (.i_Clock(clk), .i_Rst(rst_v[0]), .bus(bus0));
  response_sender #(.CLKS_PER_BIT(2)) dut1 (.i_Clock(clk), .i_Rst(rst_v[1]), .bus(bus1));

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         abort_req [2];
  int         abort_ack [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int w, input logic [7:0] b);
    if (w == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  // UART receiver model: detect start, sample each bit in its centre.
  task automatic rx_monitor(input int w, input int cpb);
    logic [9:0] bits;
    logic [7:0] exp_b;
    int         wait_n;
    int         qsize;
    forever begin
      @(negedge clk);
      if (line_w[w] == 1'b0) begin
        for (int j = 0; j < 10; j++) begin
          wait_n = (j == 0) ? cpb / 2 : cpb;
          for (int c = 0; c < wait_n; c++) @(negedge clk);
          bits[j] = line_w[w];
        end
        if (abort_req[w] != abort_ack[w]) begin
          abort_ack[w]++;
        end else begin
          chk($sformatf("dut%0d rx start", w), 32'(bits[0]), 0);
          chk($sformatf("dut%0d rx stop", w), 32'(bits[9]), 1);
          qsize = (w == 0) ? q0.size() : q1.size();
          if (qsize == 0) begin
            chk($sformatf("dut%0d rx unexpected byte %02h", w, bits[8:1]), 1, 0);
          end else begin
            exp_b = (w == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d rx byte", w), 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
    end
  endtask

  // Call at the negedge of acceptance cycle N; returns at the negedge of N+20*cpb+1.
  // mode 0: single pulse; 1: hold i_Send and present next values; 2: disturb while busy.
  task automatic frame(input int w, input int cpb, input logic [7:0] code, input logic [7:0] data,
                       input int mode, input logic [7:0] ncode, input logic [7:0] ndata);
    logic [19:0] fb;
    logic        exp_line;
    int          total;
    fb    = {1'b1, data, 1'b0, 1'b1, code, 1'b0};
    total = 20 * cpb;
    send_v[w] = 1'b1;
    code_v[w] = code;
    data_v[w] = data;
    push_exp(w, code);
    push_exp(w, data);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      exp_line = (k <= total) ? fb[(k - 1) / cpb] : 1'b1;
      chk($sformatf("dut%0d line c%0d", w, k), 32'(line_w[w]), 32'(exp_line));
      chk($sformatf("dut%0d busy c%0d", w, k), 32'(busy_w[w]), 32'(k <= total));
      chk($sformatf("dut%0d done c%0d", w, k), 32'(done_w[w]), 32'(k == total + 1));
      if (k == 1) begin
        case (mode)
          1: begin code_v[w] = ncode; data_v[w] = ndata; end
          2: begin code_v[w] = ~code; data_v[w] = ~data; send_v[w] = 1'b0; end
          default: send_v[w] = 1'b0;
        endcase
      end
      if (mode == 2 && (k == 10 || k == 45)) send_v[w] = 1'b1;
      if (mode == 2 && (k == 11 || k == 46)) send_v[w] = 1'b0;
    end
  endtask

  // Start a frame, reset it at N+rst_at, return at the negedge of N+resume_at.
  task automatic reset_mid(input int w, input int cpb, input logic [7:0] code, input logic [7:0] data,
                           input int rst_at, input int resume_at);
    logic [19:0] fb;
    fb = {1'b1, data, 1'b0, 1'b1, code, 1'b0};
    send_v[w] = 1'b1;
    code_v[w] = code;
    data_v[w] = data;
    for (int k = 1; k <= resume_at; k++) begin
      @(negedge clk);
      if (k <= rst_at) begin
        chk($sformatf("dut%0d rst line c%0d", w, k), 32'(line_w[w]), 32'(fb[(k - 1) / cpb]));
        chk($sformatf("dut%0d rst busy c%0d", w, k), 32'(busy_w[w]), 1);
      end else begin
        chk($sformatf("dut%0d rst line c%0d", w, k), 32'(line_w[w]), 1);
        chk($sformatf("dut%0d rst busy c%0d", w, k), 32'(busy_w[w]), 0);
      end
      chk($sformatf("dut%0d rst done c%0d", w, k), 32'(done_w[w]), 0);
      if (k == 1) send_v[w] = 1'b0;
      if (k == rst_at) begin
        rst_v[w] = 1'b1;
        abort_req[w]++;
      end
      if (k == rst_at + 1) rst_v[w] = 1'b0;
    end
  endtask

  initial begin
    rst_v     = 2'b11;
    send_v    = 2'b00;
    code_v[0] = 8'h00; code_v[1] = 8'h00;
    data_v[0] = 8'h00; data_v[1] = 8'h00;
    abort_req[0] = 0; abort_req[1] = 0;
    abort_ack[0] = 0; abort_ack[1] = 0;
    fork
      rx_monitor(0, 4);
      rx_monitor(1, 2);
    join_none
    repeat (3) @(negedge clk);
    rst_v = 2'b00;

    // Reset state and idle line.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("dut%0d idle line", w), 32'(line_w[w]), 1);
        chk($sformatf("dut%0d idle busy", w), 32'(busy_w[w]), 0);
        chk($sformatf("dut%0d idle done", w), 32'(done_w[w]), 0);
      end
    end

    frame(0, 4, 8'hCA, 8'h35, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    // i_Send held high: back-to-back frames with one idle cycle.
    frame(0, 4, 8'h12, 8'h34, 1, 8'hA5, 8'h5A);
    frame(0, 4, 8'hA5, 8'h5A, 0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Inputs changed and i_Send pulsed while busy.
    frame(0, 4, 8'h3C, 8'hC3, 2, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Reset part-way through, then a clean frame.
    reset_mid(0, 4, 8'h77, 8'h88, 30, 40);
    frame(0, 4, 8'h96, 8'h69, 0, 8'h00, 8'h00);
    @(negedge clk);

    // Reset wins over a simultaneous i_Send.
    rst_v[0]  = 1'b1;
    send_v[0] = 1'b1;
    code_v[0] = 8'hAA;
    @(negedge clk);
    chk("dut0 rst-prio busy", 32'(busy_w[0]), 0);
    chk("dut0 rst-prio line", 32'(line_w[0]), 1);
    chk("dut0 rst-prio done", 32'(done_w[0]), 0);
    rst_v[0]  = 1'b0;
    send_v[0] = 1'b0;
    @(negedge clk);
    chk("dut0 rst-prio busy after", 32'(busy_w[0]), 0);
    chk("dut0 rst-prio line after", 32'(line_w[0]), 1);

    // Boundary bytes, and the minimum bit period.
    frame(0, 4, 8'h00, 8'hFF, 0, 8'h00, 8'h00);
    frame(1, 2, 8'h00, 8'hFF, 1, 8'hFF, 8'h00);
    frame(1, 2, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
    frame(1, 2, 8'h81, 8'h7E, 0, 8'h00, 8'h00);

    repeat (12) @(negedge clk);
    chk("dut0 rx queue drained", q0.size(), 0);
    chk("dut1 rx queue drained", q1.size(), 0);
    chk("dut0 abandoned frame seen", abort_ack[0], abort_req[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
